instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Instruction fetch/decode sequencer for the 8-bit RISC CPU: it fetches each 8-bit instruction from the 32x8 program memory at the current PC, latches it in an instruction register, and drives the opcode, operand address, SKZ compare and enable/load strobes that the program counter consumes. It sits between program memory, the accumulator/ALU and the program counter, and is the sole source of the PC's `Opcode`, `addr`, `SKZ_cmp`, `Load_in` and `En_cpu_in` inputs.

## Interface
- No parameters; widths fixed: data 8, address 5, opcode 3.
- clock  in  1  system clock, all state on rising edge
- reset  in  1  reset, asynchronous, active-high
- pc  in  5  current program counter value
- mem_rdata  in  8  program/data memory read data; valid the cycle after `mem_rd`
- acc  in  8  accumulator value, used for SKZ
- load_req  in  1  program loader request; aborts execution
- load_done  in  1  loader finished; resume fetch at address 0
- mem_addr  out  5  memory address
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe (STO)
- opcode  out  3  IR[7:5] → PC `Opcode`
- operand  out  5  IR[4:0] → PC `addr`
- skz_cmp  out  1  registered `acc == 0` → PC `SKZ_cmp`
- pc_load  out  1  → PC `Load_in`
- pc_en  out  1  single-cycle PC advance → PC `En_cpu_in`
- alu_en  out  1  ALU operation strobe (ADD/AND/XOR)
- acc_ld  out  1  accumulator load strobe (ADD/AND/XOR/LDA)
- halted  out  1  CPU stopped on HLT

## Operation
- Opcodes:
  - HLT=000
  - SKZ=001
  - ADD=010
  - AND=011
  - XOR=100
  - LDA=101
  - STO=110
  - JMP=111
- Instruction word: [7:5] opcode, [4:0] operand.
- FSM states:
  - INST_ADDR → INST_FETCH → INST_LOAD → IDLE → OP_ADDR → OP_FETCH → ALU_OP → STORE → INST_ADDR
  - Plus HALT and LOAD.
- Moore outputs, decoded from state and IR:
  - INST_ADDR, INST_FETCH, INST_LOAD, IDLE: `mem_addr=pc`. All other states: `mem_addr=operand`.
  - `mem_rd=1` in INST_FETCH and INST_LOAD. Also in OP_FETCH and ALU_OP when opcode is ADD/AND/XOR/LDA.
  - INST_LOAD: IR <= `mem_rdata` at exit.
  - IDLE: if IR opcode==HLT, next state is HALT instead of OP_ADDR.
  - OP_ADDR: `skz_cmp` <= (`acc`==0).
  - ALU_OP: `alu_en=1` for ADD/AND/XOR; `acc_ld=1` for ADD/AND/XOR/LDA.
  - STORE: `mem_wr=1` iff opcode==STO; `pc_en=1` for every opcode.
- HALT: `halted=1`; no strobes; held until reset or `load_req`.
- LOAD: `pc_load=1`, IR cleared to 0, `skz_cmp` cleared; exits to INST_ADDR on the cycle `load_done`=1.
- `load_req`=1 in any state: next state LOAD, aborting the current instruction; no `mem_wr` or `pc_en` is issued after the request edge.
- `load_req` and `load_done` both high in LOAD: stay in LOAD.

## Timing
- Reset values:
  - state INST_ADDR, IR=0x00, `skz_cmp=0`
  - outputs: `mem_addr=pc`, `opcode=000`, `operand=0`
  - all strobes 0, `halted=0`
- Non-HLT instruction: exactly 8 cycles. `pc_en` is high for exactly 1 cycle (STORE), so the PC updates on the STORE→INST_ADDR edge.
- HLT: 4 cycles to HALT; `pc_en` never asserted.
- Memory read latency: 1 cycle. IR captures data 2 edges after entering INST_FETCH.
- `opcode`/`operand` are stable from INST_LOAD exit through STORE.
- `skz_cmp` is stable during `pc_en`, so PC computes +2 when `acc` was 0 in OP_ADDR.
- Reset mid-instruction: immediate return to reset values, asynchronous.

## Structure
- Shared package `cpu_pkg`: opcode constants and state encoding localparams, also used by the ALU and PC.
- One sub-module `instr_decoder`: combinational, IR + state → strobes.
- FSM and IR stay in `instr_sequencer`.

## Test plan
- Reset, then memory[0]=0xA5 (LDA 5): `mem_rd` in cycles 2-3 and 6-7, `acc_ld` in cycle 7, `pc_en` in cycle 8 only, `operand=5`.
- SKZ with acc=0x00, then acc=0x01 (pc=3): `skz_cmp=1` / `0` during `pc_en`; PC next 5 / 4.
- JMP 0x1A (memory = 0xFA): `opcode=111`, `operand=0x1A` during `pc_en`; next INST_ADDR `mem_addr=0x1A`.
- STO 0x10 (0xD0): `mem_wr=1` only in STORE with `mem_addr=0x10`; no `acc_ld`.
- HLT (0x00): `halted=1` from cycle 5, `pc_en` never pulses over 20 cycles; `load_req` exits.
- `load_req` in ALU_OP of STO: no `mem_wr`/`pc_en`, `pc_load=1` until `load_done`, then fetch from `mem_addr=0` once the PC reaches 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes and sequencer state encoding shared by the sequencer, ALU and PC
package cpu_pkg;
   localparam logic [2:0] OP_HLT = 3'b000;
   localparam logic [2:0] OP_SKZ = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_LDA = 3'b101;
   localparam logic [2:0] OP_STO = 3'b110;
   localparam logic [2:0] OP_JMP = 3'b111;

   typedef enum logic [3:0] {
      INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE, HALT, LOAD
   } seq_state_t;

   function automatic logic is_alu(input logic [2:0] op);
      return op == OP_ADD || op == OP_AND || op == OP_XOR;
   endfunction

   function automatic logic reads_operand(input logic [2:0] op);
      return is_alu(op) || op == OP_LDA;
   endfunction
endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: Moore strobe decode from sequencer state and instruction register
module instr_decoder
   import cpu_pkg::*;
(
   input  seq_state_t state,
   input  logic [7:0] ir,
   input  logic [4:0] pc,
   output logic [4:0] mem_addr,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       pc_load,
   output logic       pc_en,
   output logic       alu_en,
   output logic       acc_ld,
   output logic       halted
);
   logic [2:0] op;
   logic       inst_phase;
   always_comb begin
      op         = ir[7:5];
      inst_phase = state inside {INST_ADDR, INST_FETCH, INST_LOAD, IDLE};
      mem_addr   = inst_phase ? pc : ir[4:0];
      mem_rd     = (state inside {INST_FETCH, INST_LOAD}) ||
                   ((state inside {OP_FETCH, ALU_OP}) && reads_operand(op));
      mem_wr     = state == STORE && op == OP_STO;
      pc_en      = state == STORE;
      alu_en     = state == ALU_OP && is_alu(op);
      acc_ld     = state == ALU_OP && reads_operand(op);
      pc_load    = state == LOAD;
      halted     = state == HALT;
   end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: instruction fetch/decode FSM driving memory, ALU and PC control
module instr_sequencer
   import cpu_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [4:0] pc,
   input  logic [7:0] mem_rdata,
   input  logic [7:0] acc,
   input  logic       load_req,
   input  logic       load_done,
   output logic [4:0] mem_addr,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic [2:0] opcode,
   output logic [4:0] operand,
   output logic       skz_cmp,
   output logic       pc_load,
   output logic       pc_en,
   output logic       alu_en,
   output logic       acc_ld,
   output logic       halted
);
   seq_state_t state, state_nxt;
   logic [7:0] ir;

   assign opcode  = ir[7:5];
   assign operand = ir[4:0];

   always_ff @(posedge clock or posedge reset)
      if (reset) state <= INST_ADDR;
      else       state <= state_nxt;

   // a loader request wipes the instruction so nothing stale survives into LOAD
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         ir      <= '0;
         skz_cmp <= 1'b0;
      end else if (load_req || state == LOAD) begin
         ir      <= '0;
         skz_cmp <= 1'b0;
      end else begin
         if (state == INST_LOAD) ir <= mem_rdata;
         if (state == OP_ADDR) skz_cmp <= acc == 8'h00;
      end

   always_comb begin
      state_nxt = state;
      case (state)
         INST_ADDR:  state_nxt = INST_FETCH;
         INST_FETCH: state_nxt = INST_LOAD;
         INST_LOAD:  state_nxt = IDLE;
         IDLE:       state_nxt = opcode == OP_HLT ? HALT : OP_ADDR;
         OP_ADDR:    state_nxt = OP_FETCH;
         OP_FETCH:   state_nxt = ALU_OP;
         ALU_OP:     state_nxt = STORE;
         STORE:      state_nxt = INST_ADDR;
         HALT:       state_nxt = HALT;
         LOAD:       state_nxt = load_done ? INST_ADDR : LOAD;
         default:    state_nxt = INST_ADDR;
      endcase
      if (load_req) state_nxt = LOAD;
   end

   instr_decoder u_dec (
      .state   (state),
      .ir      (ir),
      .pc      (pc),
      .mem_addr(mem_addr),
      .mem_rd  (mem_rd),
      .mem_wr  (mem_wr),
      .pc_load (pc_load),
      .pc_en   (pc_en),
      .alu_en  (alu_en),
      .acc_ld  (acc_ld),
      .halted  (halted)
   );
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed and randomized checks against a phase-counting reference model
module tb_instr_sequencer;
   logic       clock = 0, reset = 0;
   logic [4:0] pc = 0;
   logic [7:0] mem_rdata = 0, acc = 0;
   logic       load_req = 0, load_done = 0;
   logic [4:0] mem_addr, operand;
   logic [2:0] opcode;
   logic       mem_rd, mem_wr, skz_cmp, pc_load, pc_en, alu_en, acc_ld, halted;
   logic [7:0] mem [32];
   int         checks = 0, errors = 0;
   logic       chk_on = 0;

   instr_sequencer dut (
      .clock(clock), .reset(reset), .pc(pc), .mem_rdata(mem_rdata), .acc(acc),
      .load_req(load_req), .load_done(load_done), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_wr(mem_wr), .opcode(opcode), .operand(operand), .skz_cmp(skz_cmp),
      .pc_load(pc_load), .pc_en(pc_en), .alu_en(alu_en), .acc_ld(acc_ld), .halted(halted)
   );

   always #5 clock = ~clock;

   // environment: registered program memory and the program counter
   always @(posedge clock) if (mem_rd) mem_rdata <= mem[mem_addr];
   always @(posedge clock or posedge reset)
      if (reset) pc <= 0;
      else if (pc_load) pc <= 0;
      else if (pc_en) pc <= opcode == 3'b111 ? operand : pc + ((opcode == 3'b001 && skz_cmp) ? 5'd2 : 5'd1);

   // reference: cycle index within an 8-cycle instruction plus run/halt/load mode
   int         ph = 0, mode = 0;
   logic [7:0] m_ir = 0;
   logic       m_skz = 0;
   always @(posedge clock or posedge reset)
      if (reset) begin
         ph = 0; mode = 0; m_ir = 0; m_skz = 0;
      end else if (load_req) begin
         mode = 2; m_ir = 0; m_skz = 0;
      end else if (mode == 2) begin
         if (load_done) begin mode = 0; ph = 0; end
      end else if (mode == 0) begin
         if (ph == 2) m_ir = mem_rdata;
         if (ph == 4) m_skz = acc == 0;
         if (ph == 3 && m_ir[7:5] == 3'd0) mode = 1;
         else ph = (ph + 1) % 8;
      end

   logic [20:0] exp_v, act_v;
   always @(negedge clock) if (chk_on) begin
      logic [2:0] op;
      logic       run, rd;
      op    = m_ir[7:5];
      run   = mode == 0;
      rd    = op >= 3'd2 && op <= 3'd5;
      exp_v = {(run && ph < 4) ? pc : m_ir[4:0],
               run && (ph == 1 || ph == 2 || (rd && (ph == 5 || ph == 6))),
               run && ph == 7 && op == 3'd6, op, m_ir[4:0], m_skz, mode == 2,
               run && ph == 7, run && ph == 6 && op >= 3'd2 && op <= 3'd4,
               run && ph == 6 && rd, mode == 1};
      act_v = {mem_addr, mem_rd, mem_wr, opcode, operand, skz_cmp, pc_load, pc_en, alu_en, acc_ld, halted};
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         $display("FAIL cycle outputs t=%0t got %h expected %h", $time, act_v, exp_v);
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   task automatic wait_pc_en(input string name);
      int n = 0;
      while (pc_en !== 1'b1 && n < 20) begin @(negedge clock); n++; end
      chk({name, " pc_en seen"}, 32'(pc_en), 1);
   endtask

   initial begin
      logic [8:0] rd_m, ld_m, en_m;
      int         pen, h4, h5;
      for (int i = 0; i < 32; i++) mem[i] = 8'hA0;
      mem[0] = 8'hA5; mem[1] = 8'h20; mem[3] = 8'h20; mem[4] = 8'hFA;
      mem[26] = 8'hD0; mem[27] = 8'h00;
      #1 reset = 1; chk_on = 1;
      @(negedge clock); @(negedge clock);
      chk("reset mem_addr", 32'(mem_addr), 0);
      chk("reset strobes", 32'({mem_rd, mem_wr, pc_load, pc_en, alu_en, acc_ld, halted, skz_cmp}), 0);
      chk("reset ir", 32'({opcode, operand}), 0);
      #1 reset = 0;
      #1 rd_m = 0; ld_m = 0; en_m = 0;
      for (int c = 1; c <= 8; c++) begin
         if (c > 1) @(negedge clock);
         rd_m[c] = mem_rd; ld_m[c] = acc_ld; en_m[c] = pc_en;
      end
      chk("lda mem_rd cycles", 32'(rd_m), 32'h0CC);
      chk("lda acc_ld cycles", 32'(ld_m), 32'h080);
      chk("lda pc_en cycles", 32'(en_m), 32'h100);
      chk("lda operand", 32'(operand), 5);
      @(negedge clock); chk("lda next addr", 32'(mem_addr), 1);
      #1 acc = 0;
      wait_pc_en("skz0"); chk("skz0 skz_cmp", 32'(skz_cmp), 1);
      @(negedge clock); chk("skz0 next addr", 32'(mem_addr), 3);
      #1 acc = 1;
      wait_pc_en("skz1"); chk("skz1 skz_cmp", 32'(skz_cmp), 0);
      @(negedge clock); chk("skz1 next addr", 32'(mem_addr), 4);
      wait_pc_en("jmp"); chk("jmp op/operand", 32'({opcode, operand}), 32'hFA);
      @(negedge clock); chk("jmp next addr", 32'(mem_addr), 32'h1A);
      wait_pc_en("sto");
      chk("sto mem_wr", 32'(mem_wr), 1); chk("sto addr", 32'(mem_addr), 32'h10); chk("sto acc_ld", 32'(acc_ld), 0);
      @(negedge clock);
      pen = 0; h4 = 0; h5 = 0;
      for (int c = 1; c <= 24; c++) begin
         if (c > 1) @(negedge clock);
         if (c == 4) h4 = halted;
         if (c == 5) h5 = halted;
         pen += pc_en;
      end
      chk("hlt cycle4 halted", 32'(h4), 0); chk("hlt cycle5 halted", 32'(h5), 1); chk("hlt pc_en count", 32'(pen), 0);
      #1 load_req = 1; mem[0] = 8'hD3;
      @(negedge clock); chk("load pc_load", 32'(pc_load), 1); chk("load halted", 32'(halted), 0);
      #1 load_req = 0;
      repeat (3) @(negedge clock);
      chk("load held", 32'(pc_load), 1);
      #1 load_done = 1;
      @(negedge clock); chk("resume addr", 32'(mem_addr), 0); chk("resume pc_load", 32'(pc_load), 0);
      #1 load_done = 0;
      repeat (6) @(negedge clock);
      #1 load_req = 1;
      @(negedge clock);
      chk("abort pc_load", 32'(pc_load), 1); chk("abort wr/en", 32'({mem_wr, pc_en}), 0);
      #1 load_req = 0;
      @(negedge clock); #1 load_done = 1;
      @(negedge clock); chk("abort resume addr", 32'(mem_addr), 0);
      #1 load_done = 0;
      repeat (5) @(negedge clock);
      @(posedge clock); #2 reset = 1;
      #1 chk("async reset", 32'({mem_addr, mem_rd, opcode, operand, pc_en, halted}), 0);
      @(negedge clock); #1 reset = 0;
      for (int k = 0; k < 4000; k++) begin
         @(negedge clock); #1;
         acc = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         load_req = $urandom_range(0, 59) == 0;
         load_done = $urandom_range(0, 2) == 0;
         if (k % 200 == 0) mem[$urandom_range(0, 31)] = 8'($urandom);
      end
      @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
